// File: rtl/rob_multi_wb.sv
// Reorder buffer: in-order allocation, out-of-order completion over NUM_WB writeback
// channels, in-order retirement one entry per cycle, with full flush on a mispredicted branch.
module rob_multi_wb #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int ROB_TYPE_BIT = 2,
    parameter int NUM_WB       = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    output logic                           rob_full,
    output logic [ROB_SIZE_BIT-1:0]        rob_free_id,
    input  logic                           rob_input,
    input  logic [31:0]                    rob_value,
    input  logic [31:0]                    rob_addr,
    input  logic [ROB_TYPE_BIT-1:0]        rob_type,
    input  logic [4:0]                     rob_reg_id,
    input  logic                           rob_fi,
    input  logic [ROB_SIZE_BIT-1:0]        rob_qry1_id,
    output logic                           rob_qry1_ready,
    output logic [31:0]                    rob_qry1_value,
    input  logic [ROB_SIZE_BIT-1:0]        rob_qry2_id,
    output logic                           rob_qry2_ready,
    output logic [31:0]                    rob_qry2_value,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*ROB_SIZE_BIT-1:0] wb_rob_id,
    input  logic [NUM_WB*32-1:0]           wb_value,
    input  logic [NUM_WB-1:0]              wb_mispred,
    output logic                           commit_valid,
    output logic [ROB_SIZE_BIT-1:0]        commit_rob_id,
    output logic [4:0]                     commit_reg_id,
    output logic [31:0]                    commit_value,
    output logic                           write_back,
    output logic                           rob_clear,
    output logic [31:0]                    rob_rst_addr,
    output logic                           rob_exit
);

    localparam int DEPTH = 1 << ROB_SIZE_BIT;
    localparam int CNT_W = ROB_SIZE_BIT + 1;
    localparam logic [ROB_TYPE_BIT-1:0] TYPE_REG    = ROB_TYPE_BIT'(0);
    localparam logic [ROB_TYPE_BIT-1:0] TYPE_STORE  = ROB_TYPE_BIT'(1);
    localparam logic [ROB_TYPE_BIT-1:0] TYPE_BRANCH = ROB_TYPE_BIT'(2);
    localparam logic [ROB_TYPE_BIT-1:0] TYPE_EXIT   = ROB_TYPE_BIT'(3);

    typedef logic [ROB_SIZE_BIT-1:0] id_t;

    id_t              head, tail;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] ent_valid, ent_ready, ent_mispred;
    logic [31:0]             ent_value [DEPTH];
    logic [4:0]              ent_reg   [DEPTH];
    logic [ROB_TYPE_BIT-1:0] ent_type  [DEPTH];

    logic do_alloc, head_done, do_flush;
    logic unused_addr;

    // The PC travels with the instruction but retirement only needs the resolved value.
    assign unused_addr = ^rob_addr;

    assign rob_full    = (count == CNT_W'(DEPTH));
    assign rob_free_id = tail;

    assign do_alloc  = rob_input && !rob_full;
    assign head_done = ent_valid[head] && ent_ready[head] && !rob_exit;
    assign do_flush  = head_done && (ent_type[head] == TYPE_BRANCH) && ent_mispred[head];

    function automatic id_t wb_id(input int k);
        return wb_rob_id[k*ROB_SIZE_BIT +: ROB_SIZE_BIT];
    endfunction

    // Returns {ready, value}; walking channels high-to-low leaves the lowest channel in place.
    function automatic logic [32:0] query(input id_t q);
        logic        rdy;
        logic [31:0] val;
        rdy = ent_ready[q];
        val = ent_value[q];
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            if (wb_valid[k] && (wb_id(k) == q)) begin
                rdy = 1'b1;
                val = wb_value[k*32 +: 32];
            end
        end
        if (!ent_valid[q]) begin
            rdy = 1'b0;
            val = '0;
        end
        return {rdy, val};
    endfunction

    always_comb begin
        {rob_qry1_ready, rob_qry1_value} = query(rob_qry1_id);
        {rob_qry2_ready, rob_qry2_value} = query(rob_qry2_id);
    end

    // Entry payload: no reset needed, everything downstream is qualified by ent_valid.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_valid[k] && ent_valid[wb_id(k)]) begin
                    ent_value[wb_id(k)]   <= wb_value[k*32 +: 32];
                    ent_mispred[wb_id(k)] <= wb_mispred[k];
                end
            end
            if (do_alloc) begin
                ent_value[tail]   <= rob_value;
                ent_reg[tail]     <= rob_reg_id;
                ent_type[tail]    <= rob_type;
                ent_mispred[tail] <= 1'b0;
            end
        end
    end

    // Queue pointers, per-entry status and registered retirement outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_ready     <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            commit_reg_id <= '0;
            commit_value  <= '0;
            write_back    <= 1'b0;
            rob_clear     <= 1'b0;
            rob_rst_addr  <= '0;
            rob_exit      <= 1'b0;
        end else begin
            commit_valid <= 1'b0;
            write_back   <= 1'b0;
            rob_clear    <= 1'b0;
            if (rdy_in) begin
                if (do_flush) begin
                    head      <= '0;
                    tail      <= '0;
                    count     <= '0;
                    ent_valid <= '0;
                    ent_ready <= '0;
                end else begin
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_valid[k] && ent_valid[wb_id(k)])
                            ent_ready[wb_id(k)] <= 1'b1;
                    end
                    if (head_done) begin
                        ent_valid[head] <= 1'b0;
                        head            <= head + id_t'(1);
                    end
                    if (do_alloc) begin
                        ent_valid[tail] <= 1'b1;
                        ent_ready[tail] <= rob_fi;
                        tail            <= tail + id_t'(1);
                    end
                    count <= count + CNT_W'(do_alloc) - CNT_W'(head_done);
                end
                if (head_done) begin
                    commit_valid  <= 1'b1;
                    commit_rob_id <= head;
                    commit_reg_id <= (ent_type[head] == TYPE_REG) ? ent_reg[head] : 5'd0;
                    commit_value  <= ent_value[head];
                    write_back    <= (ent_type[head] == TYPE_STORE);
                    if (ent_type[head] == TYPE_EXIT)
                        rob_exit <= 1'b1;
                end
                if (do_flush) begin
                    rob_clear    <= 1'b1;
                    rob_rst_addr <= ent_value[head];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed bench for rob_multi_wb: reset, fill, out-of-order completion, bypass, flush,
// store retirement, freeze and exit.
module tb_rob_multi_wb;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        rob_full;
    logic [3:0]  rob_free_id;
    logic        rob_input;
    logic [31:0] rob_value, rob_addr;
    logic [1:0]  rob_type;
    logic [4:0]  rob_reg_id;
    logic        rob_fi;
    logic [3:0]  rob_qry1_id, rob_qry2_id;
    logic        rob_qry1_ready, rob_qry2_ready;
    logic [31:0] rob_qry1_value, rob_qry2_value;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_value;
    logic [1:0]  wb_mispred;
    logic        commit_valid;
    logic [3:0]  commit_rob_id;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_value;
    logic        write_back, rob_clear;
    logic [31:0] rob_rst_addr;
    logic        rob_exit;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    rob_multi_wb #(.ROB_SIZE_BIT(4), .ROB_TYPE_BIT(2), .NUM_WB(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .rob_free_id(rob_free_id),
        .rob_input(rob_input), .rob_value(rob_value), .rob_addr(rob_addr),
        .rob_type(rob_type), .rob_reg_id(rob_reg_id), .rob_fi(rob_fi),
        .rob_qry1_id(rob_qry1_id), .rob_qry1_ready(rob_qry1_ready), .rob_qry1_value(rob_qry1_value),
        .rob_qry2_id(rob_qry2_id), .rob_qry2_ready(rob_qry2_ready), .rob_qry2_value(rob_qry2_value),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value), .wb_mispred(wb_mispred),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_reg_id(commit_reg_id),
        .commit_value(commit_value), .write_back(write_back), .rob_clear(rob_clear),
        .rob_rst_addr(rob_rst_addr), .rob_exit(rob_exit)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; rob_input = 1'b0; rob_value = '0; rob_addr = '0; rob_type = '0;
        rob_reg_id = '0; rob_fi = 1'b0; rob_qry1_id = '0; rob_qry2_id = '0;
        wb_valid = '0; wb_rob_id = '0; wb_value = '0; wb_mispred = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic fi,
                             input logic [31:0] v);
        rob_input = 1'b1; rob_type = t; rob_reg_id = rd; rob_fi = fi; rob_value = v;
        rob_addr = 32'h100 + {27'd0, rd};
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(2'd0, 5'd1, 1'b0, 32'h10 + i);
            tick();
        end
        rob_input = 1'b0;
        rob_qry1_id = 4'd2;
        #1;
        checks++; if (rob_free_id !== 4'd5) begin errors++; $display("FAIL reset_pre_free_id got %0d want 5", rob_free_id); end
        rst_in = 1'b0;
        #1;
        checks++; if (rob_free_id !== 4'd0) begin errors++; $display("FAIL reset_free_id got %0d want 0", rob_free_id); end
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d want 0", rob_full); end
        checks++; if (rob_qry1_ready !== 1'b0 || rob_qry1_value !== 32'd0) begin errors++; $display("FAIL reset_query got %0d/%h want 0/0", rob_qry1_ready, rob_qry1_value); end
        checks++; if ({commit_valid, write_back, rob_clear, rob_exit} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {commit_valid, write_back, rob_clear, rob_exit}); end
        checks++; if (commit_value !== 32'd0 || rob_rst_addr !== 32'd0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", commit_value, rob_rst_addr); end
        tick();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(2'd0, 5'd1, 1'b0, 32'h200 + i);
            checks++; if (rob_free_id !== 4'(i)) begin errors++; $display("FAIL fill_free_id got %0d want %0d", rob_free_id, i); end
            if (i == 15) begin
                checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL fill_not_full_at_15 got %0d want 0", rob_full); end
            end
            tick();
        end
        checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0d want 1", rob_full); end
        checks++; if (rob_free_id !== 4'd0) begin errors++; $display("FAIL fill_wrap got %0d want 0", rob_free_id); end
        set_alloc(2'd0, 5'd2, 1'b1, 32'hDEAD);
        tick();
        rob_input = 1'b0;
        checks++; if (rob_full !== 1'b1 || rob_free_id !== 4'd0) begin errors++; $display("FAIL fill_17th got full=%0d id=%0d want 1/0", rob_full, rob_free_id); end
        rob_qry1_id = 4'd0;
        #1;
        checks++; if (rob_qry1_ready !== 1'b0 || rob_qry1_value !== 32'h200) begin errors++; $display("FAIL fill_17th_entry got %0d/%h want 0/200", rob_qry1_ready, rob_qry1_value); end
        tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL fill_no_commit got %0d want 0", commit_valid); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        set_alloc(2'd0, 5'd5, 1'b0, 32'h0); tick();
        set_alloc(2'd0, 5'd6, 1'b0, 32'h0); tick();
        set_alloc(2'd0, 5'd7, 1'b0, 32'h0); tick();
        rob_input = 1'b0;
        wb_valid = 2'b11; wb_rob_id = {4'd0, 4'd2}; wb_value = {32'h11, 32'h22};
        tick();
        wb_valid = 2'b00;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_wb_edge_commit got %0d want 0", commit_valid); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_reg_id !== 5'd5 || commit_value !== 32'h11 || commit_rob_id !== 4'd0) begin errors++; $display("FAIL ooo_commit0 got v=%0d rd=%0d val=%h id=%0d want 1/5/11/0", commit_valid, commit_reg_id, commit_value, commit_rob_id); end
        tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_stall got %0d want 0", commit_valid); end
        wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd1}; wb_value = {32'h0, 32'h33};
        tick();
        wb_valid = 2'b00;
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_reg_id !== 5'd6 || commit_value !== 32'h33) begin errors++; $display("FAIL ooo_commit1 got v=%0d rd=%0d val=%h want 1/6/33", commit_valid, commit_reg_id, commit_value); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_reg_id !== 5'd7 || commit_value !== 32'h22 || commit_rob_id !== 4'd2) begin errors++; $display("FAIL ooo_commit2 got v=%0d rd=%0d val=%h id=%0d want 1/7/22/2", commit_valid, commit_reg_id, commit_value, commit_rob_id); end
        tick();
        checks++; if (commit_valid !== 1'b0 || rob_free_id !== 4'd3) begin errors++; $display("FAIL ooo_drained got v=%0d id=%0d want 0/3", commit_valid, rob_free_id); end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(2'd0, 5'd8, 1'b0, (i == 3) ? 32'h99 : 32'h0);
            tick();
        end
        rob_input = 1'b0;
        rob_qry1_id = 4'd3; rob_qry2_id = 4'd5;
        #1;
        checks++; if (rob_qry1_ready !== 1'b0 || rob_qry1_value !== 32'h99) begin errors++; $display("FAIL byp_stored got %0d/%h want 0/99", rob_qry1_ready, rob_qry1_value); end
        wb_valid = 2'b11; wb_rob_id = {4'd3, 4'd3}; wb_value = {32'hB, 32'hA};
        #1;
        checks++; if (rob_qry1_ready !== 1'b1 || rob_qry1_value !== 32'hA) begin errors++; $display("FAIL byp_conflict got %0d/%h want 1/a", rob_qry1_ready, rob_qry1_value); end
        checks++; if (rob_qry2_ready !== 1'b0 || rob_qry2_value !== 32'h0) begin errors++; $display("FAIL byp_invalid_id got %0d/%h want 0/0", rob_qry2_ready, rob_qry2_value); end
        tick();
        wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd7}; wb_value = {32'h0, 32'h5};
        rob_qry2_id = 4'd7;
        #1;
        checks++; if (rob_qry1_ready !== 1'b1 || rob_qry1_value !== 32'hA) begin errors++; $display("FAIL byp_latched got %0d/%h want 1/a", rob_qry1_ready, rob_qry1_value); end
        checks++; if (rob_qry2_ready !== 1'b0 || rob_qry2_value !== 32'h0) begin errors++; $display("FAIL byp_wb_invalid got %0d/%h want 0/0", rob_qry2_ready, rob_qry2_value); end
        tick();
        wb_valid = 2'b00;
    endtask

    task automatic test_flush();
        do_reset();
        set_alloc(2'd2, 5'd3, 1'b0, 32'h2000); tick();
        set_alloc(2'd0, 5'd9, 1'b1, 32'h44);   tick();
        rob_input = 1'b0;
        wb_valid = 2'b10; wb_rob_id = {4'd0, 4'd0}; wb_value = {32'h1000, 32'h0}; wb_mispred = 2'b10;
        tick();
        wb_valid = 2'b00; wb_mispred = 2'b00;
        set_alloc(2'd0, 5'd4, 1'b1, 32'h77);
        tick();
        rob_input = 1'b0;
        rob_qry1_id = 4'd1; rob_qry2_id = 4'd2;
        #1;
        checks++; if (rob_clear !== 1'b1 || rob_rst_addr !== 32'h1000) begin errors++; $display("FAIL flush_clear got %0d/%h want 1/1000", rob_clear, rob_rst_addr); end
        checks++; if (commit_valid !== 1'b1 || commit_reg_id !== 5'd0) begin errors++; $display("FAIL flush_commit got %0d rd=%0d want 1/0", commit_valid, commit_reg_id); end
        checks++; if (rob_free_id !== 4'd0 || rob_full !== 1'b0) begin errors++; $display("FAIL flush_ptrs got id=%0d full=%0d want 0/0", rob_free_id, rob_full); end
        checks++; if (rob_qry1_ready !== 1'b0 || rob_qry2_ready !== 1'b0) begin errors++; $display("FAIL flush_entries got %0d/%0d want 0/0", rob_qry1_ready, rob_qry2_ready); end
        tick();
        checks++; if (rob_clear !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL flush_after got clr=%0d cv=%0d want 0/0", rob_clear, commit_valid); end
    endtask

    task automatic test_store_freeze();
        do_reset();
        set_alloc(2'd1, 5'd4, 1'b1, 32'h1234);
        tick();
        rdy_in = 1'b0;
        set_alloc(2'd0, 5'd6, 1'b1, 32'h55);
        tick();
        checks++; if (commit_valid !== 1'b0 || write_back !== 1'b0) begin errors++; $display("FAIL freeze_pulses got %0d/%0d want 0/0", commit_valid, write_back); end
        checks++; if (rob_free_id !== 4'd1) begin errors++; $display("FAIL freeze_free_id got %0d want 1", rob_free_id); end
        tick();
        rdy_in = 1'b1; rob_input = 1'b0;
        tick();
        checks++; if (commit_valid !== 1'b1 || write_back !== 1'b1 || commit_reg_id !== 5'd0 || commit_value !== 32'h1234) begin errors++; $display("FAIL store_commit got v=%0d wb=%0d rd=%0d val=%h want 1/1/0/1234", commit_valid, write_back, commit_reg_id, commit_value); end
        tick();
        checks++; if (write_back !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL store_pulse_end got wb=%0d v=%0d want 0/0", write_back, commit_valid); end
    endtask

    task automatic test_exit();
        do_reset();
        set_alloc(2'd3, 5'd1, 1'b1, 32'h0);  tick();
        set_alloc(2'd0, 5'd2, 1'b1, 32'h66); tick();
        rob_input = 1'b0;
        checks++; if (rob_exit !== 1'b1 || commit_valid !== 1'b1 || commit_reg_id !== 5'd0) begin errors++; $display("FAIL exit_commit got ex=%0d v=%0d rd=%0d want 1/1/0", rob_exit, commit_valid, commit_reg_id); end
        tick();
        tick();
        checks++; if (rob_exit !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL exit_stops got ex=%0d v=%0d want 1/0", rob_exit, commit_valid); end
    endtask

    initial begin
        idle_inputs();
        rst_in = 1'b0;
        test_reset();
        test_fill();
        test_out_of_order();
        test_bypass();
        test_flush();
        test_store_freeze();
        test_exit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
